// File: rtl/dsp_ctrl_pkg.sv
// Shared definitions for the DSP-slice MAC sequencer.
//   - opmode words driven to the slice (X/Z mux select, bits 7:4 always 0)
//   - sequencer state encoding
//   - slice pipeline register configuration that the sequencer timing assumes
package dsp_ctrl_pkg;

    // X=M, Z=0 : starts a new sum, so stale P never leaks into a packet
    localparam logic [7:0] OPM_MUL_ONLY = 8'h01;
    // X=M, Z=P : accumulate onto the running sum
    localparam logic [7:0] OPM_MUL_ACC  = 8'h09;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        ACCEPT = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } mac_state_e;

    // Slice configuration the sequencer is timed against
    localparam int SLICE_A0REG     = 0;
    localparam int SLICE_B0REG     = 0;
    localparam int SLICE_A1REG     = 1;
    localparam int SLICE_B1REG     = 1;
    localparam int SLICE_MREG      = 1;
    localparam int SLICE_PREG      = 1;
    localparam int SLICE_OPMODEREG = 1;
    localparam     SLICE_RSTTYPE   = "SYNC";
    localparam     SLICE_B_INPUT   = "DIRECT";

    // Opmode for the sample arriving at the opmode register this cycle.
    // With no sample in flight the accumulate word is held; it is harmless
    // because CEP is low for bubbles.
    function automatic logic [7:0] opmode_for(input logic vld, input logic first);
        return (vld && first) ? OPM_MUL_ONLY : OPM_MUL_ACC;
    endfunction

endpackage

// File: rtl/dsp_mac_sequencer_tag.sv
// dsp_tag_pipe: (valid, first) delay line that shadows samples through the
// slice pipeline.
//   clk, rst_n      clock / async active-low reset
//   in_vld          a pair is accepted this cycle
//   in_first        that pair is the first of its packet
//   op_vld/op_first tag OP_DELAY cycles after acceptance (drives opmode)
//   cep             tag valid P_LAT-1 cycles after acceptance (drives CEP)
//   last_in_p       a sample has just landed in P and nothing is behind it
module dsp_tag_pipe #(
    parameter int P_LAT    = 3,
    parameter int OP_DELAY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_vld,
    input  logic in_first,
    output logic op_vld,
    output logic op_first,
    output logic cep,
    output logic last_in_p
);

    // stage k holds the tag of the pair accepted k edges ago
    logic [P_LAT:1]    vld_pipe;
    logic [OP_DELAY:1] first_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            first_pipe <= '0;
        end else begin
            vld_pipe[1]   <= in_vld;
            first_pipe[1] <= in_vld & in_first;
            for (int i = 2; i <= P_LAT; i++)    vld_pipe[i]   <= vld_pipe[i-1];
            for (int i = 2; i <= OP_DELAY; i++) first_pipe[i] <= first_pipe[i-1];
        end
    end

    assign op_vld    = vld_pipe[OP_DELAY];
    assign op_first  = first_pipe[OP_DELAY];
    assign cep       = vld_pipe[P_LAT-1];
    // final sample reached P: dsp_p is complete for the packet this cycle
    assign last_in_p = vld_pipe[P_LAT] & ~(|vld_pipe[P_LAT-1:1]);

endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives one DSP slice as a streaming multiply-accumulate.
//   s_*     operand stream (valid/ready, s_last ends a packet)
//   m_*     result stream: sum of a*b, slice carry-out, pair count
//   dsp_*   slice A/B/OPMODE, CE (A/B/M/OPMODE), CEP, RST and P/CARRYOUT
// A packet ends on s_last or when the pair counter reaches its maximum.
module dsp_mac_sequencer
    import dsp_ctrl_pkg::*;
#(
    parameter int P_LAT    = SLICE_A0REG + SLICE_A1REG + SLICE_MREG + SLICE_PREG,
    parameter int OP_DELAY = SLICE_OPMODEREG,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [17:0]      s_a,
    input  logic [17:0]      s_b,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [47:0]      m_p,
    output logic             m_carryout,
    output logic [CNT_W-1:0] m_count,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_ce,
    output logic             dsp_cep,
    output logic             dsp_rst,
    input  logic [47:0]      dsp_p,
    input  logic             dsp_carryout
);

    // accepting with this count makes the counter saturate
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    mac_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             op_vld, op_first, last_in_p;

    assign accept = (state_q == ACCEPT) && s_valid;

    dsp_tag_pipe #(
        .P_LAT    (P_LAT),
        .OP_DELAY (OP_DELAY)
    ) u_tag (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (accept),
        .in_first  (cnt_q == '0),
        .op_vld    (op_vld),
        .op_first  (op_first),
        .cep       (dsp_cep),
        .last_in_p (last_in_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        dsp_ce  = 1'b0;
        dsp_rst = 1'b0;
        m_valid = 1'b0;
        case (state_q)
            INIT: begin
                dsp_rst = 1'b1;
                state_d = ACCEPT;
            end
            ACCEPT: begin
                s_ready = 1'b1;
                dsp_ce  = 1'b1;
                if (s_valid && (s_last || cnt_q == CNT_LAST)) state_d = DRAIN;
            end
            DRAIN: begin
                // keep M/opmode registers moving so the tail samples reach P
                dsp_ce = 1'b1;
                if (last_in_p) state_d = RESULT;
            end
            RESULT: begin
                m_valid = 1'b1;
                if (m_ready) state_d = ACCEPT;
            end
            default: state_d = INIT;
        endcase
    end

    // Operands pass straight through only while a pair is actually taken;
    // bubbles load zero, which CEP then ignores.
    assign dsp_a      = accept ? s_a : '0;
    assign dsp_b      = accept ? s_b : '0;
    assign dsp_opmode = (state_q == INIT) ? 8'h00 : opmode_for(op_vld, op_first);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == RESULT && m_ready) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Result registers load on entry to RESULT and hold until the next packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p        <= '0;
            m_carryout <= 1'b0;
            m_count    <= '0;
        end else if (state_q == DRAIN && last_in_p) begin
            m_p        <= dsp_p;
            m_carryout <= dsp_carryout;
            m_count    <= cnt_q;
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
module tb_dsp_mac_sequencer;
    import dsp_ctrl_pkg::*;

    typedef struct packed {
        logic [47:0] p;
        logic [15:0] cnt;
    } exp_t;

    logic        gclk;
    logic        grst_n;
    logic        s_valid [2];
    logic        s_ready [2];
    logic [17:0] s_a [2];
    logic [17:0] s_b [2];
    logic        s_last [2];
    logic        m_valid [2];
    logic        m_ready [2];
    logic [47:0] m_p [2];
    logic        m_carryout [2];
    logic [15:0] m_count0;
    logic [1:0]  m_count1;
    logic [17:0] dsp_a [2];
    logic [17:0] dsp_b [2];
    logic [7:0]  dsp_opmode [2];
    logic        dsp_ce [2];
    logic        dsp_cep [2];
    logic        dsp_rst [2];
    logic [47:0] dsp_p [2];
    logic        dsp_carryout [2];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc0 = 0;
    logic mv0_q = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    longint exp_sum [2];
    int     exp_cnt [2];

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;
    always @(posedge gclk) cyc <= cyc + 1;

    dsp_mac_sequencer #(.P_LAT(3), .OP_DELAY(1), .CNT_W(16)) u_dut0 (
        .clk(gclk), .rst_n(grst_n),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_a(s_a[0]), .s_b(s_b[0]), .s_last(s_last[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_p(m_p[0]), .m_carryout(m_carryout[0]),
        .m_count(m_count0),
        .dsp_a(dsp_a[0]), .dsp_b(dsp_b[0]), .dsp_opmode(dsp_opmode[0]), .dsp_ce(dsp_ce[0]),
        .dsp_cep(dsp_cep[0]), .dsp_rst(dsp_rst[0]), .dsp_p(dsp_p[0]), .dsp_carryout(dsp_carryout[0])
    );

    dsp_mac_sequencer #(.P_LAT(3), .OP_DELAY(1), .CNT_W(2)) u_dut1 (
        .clk(gclk), .rst_n(grst_n),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_a(s_a[1]), .s_b(s_b[1]), .s_last(s_last[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_p(m_p[1]), .m_carryout(m_carryout[1]),
        .m_count(m_count1),
        .dsp_a(dsp_a[1]), .dsp_b(dsp_b[1]), .dsp_opmode(dsp_opmode[1]), .dsp_ce(dsp_ce[1]),
        .dsp_cep(dsp_cep[1]), .dsp_rst(dsp_rst[1]), .dsp_p(dsp_p[1]), .dsp_carryout(dsp_carryout[1])
    );

    // Behavioural slice: A1/B1, M, OPMODE and P registers, sync reset,
    // X = M when opmode[1:0]=01, Z = P when opmode[3:2]=10.
    for (genvar g = 0; g < 2; g++) begin : g_slice
        logic [17:0]        a1, b1;
        logic signed [35:0] m;
        logic [7:0]         opr;
        logic [47:0]        p;
        logic               co;
        logic [47:0]        xm, zp;
        logic [48:0]        sum;

        always_comb begin
            xm  = (opr[1:0] == 2'b01) ? {{12{m[35]}}, m} : 48'd0;
            zp  = (opr[3:2] == 2'b10) ? p : 48'd0;
            sum = {1'b0, xm} + {1'b0, zp};
        end

        always @(posedge gclk) begin
            if (dsp_rst[g]) begin
                a1 <= '0; b1 <= '0; m <= '0; opr <= '0; p <= '0; co <= 1'b0;
            end else begin
                if (dsp_ce[g]) begin
                    a1  <= dsp_a[g];
                    b1  <= dsp_b[g];
                    m   <= $signed(a1) * $signed(b1);
                    opr <= dsp_opmode[g];
                end
                if (dsp_cep[g]) begin
                    p  <= sum[47:0];
                    co <= sum[48];
                end
            end
        end

        assign dsp_p[g]        = p;
        assign dsp_carryout[g] = co;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int g);
        exp_t   e;
        longint s;
        s     = exp_sum[g];
        e.p   = s[47:0];
        e.cnt = exp_cnt[g][15:0];
        if (g == 0) q0.push_back(e);
        else        q1.push_back(e);
        exp_sum[g] = 0;
        exp_cnt[g] = 0;
    endtask

    // Presents one pair, waits (bounded) until it is taken, updates the model.
    // Leaves s_valid high so calls can run back-to-back.
    task automatic send(input int g, input logic [17:0] a, input logic [17:0] b, input logic last);
        int n;
        s_valid[g] = 1'b1;
        s_a[g]     = a;
        s_b[g]     = b;
        s_last[g]  = last;
        n = 0;
        while (!s_ready[g] && n < 100) begin
            @(posedge gclk); #1;
            n++;
        end
        chk($sformatf("send_ready%0d", g), {63'd0, s_ready[g]}, 64'd1);
        @(posedge gclk); #1;
        if (g == 0) acc_cyc0 = cyc;
        exp_sum[g] += longint'($signed(a)) * longint'($signed(b));
        exp_cnt[g]++;
        if (last || (g == 1 && exp_cnt[g] == 3)) push_exp(g);
    endtask

    task automatic idle(input int g, input int n);
        s_valid[g] = 1'b0;
        repeat (n) begin @(posedge gclk); #1; end
    endtask

    task automatic wait_q(input int g);
        int n;
        n = 0;
        while (((g == 0) ? q0.size() : q1.size()) != 0 && n < 60) begin
            @(posedge gclk); #1;
            n++;
        end
        chk($sformatf("result_seen%0d", g), 64'((g == 0) ? q0.size() : q1.size()), 64'd0);
        @(posedge gclk); #1;
    endtask

    task automatic take_result(input int g, input logic [47:0] p, input logic [15:0] c, input logic co);
        exp_t e;
        int   sz;
        sz = (g == 0) ? q0.size() : q1.size();
        checks++;
        assert (sz != 0) else begin
            errors++;
            $error("FAIL unexpected_result%0d: observed m_p 0x%0h expected no result", g, p);
        end
        if (sz != 0) begin
            e = (g == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("m_p%0d", g), 64'(p), 64'(e.p));
            chk($sformatf("m_count%0d", g), 64'(c), 64'(e.cnt));
            chk($sformatf("m_carryout%0d", g), {63'd0, co}, 64'd0);
        end
    endtask

    // Result monitor: sampled mid-cycle, handshake completes on the next edge
    always @(negedge gclk) begin
        if (grst_n && m_valid[0] && !mv0_q)
            chk("latency_edges", 64'(cyc - acc_cyc0 + 1), 64'd4);
        mv0_q <= m_valid[0];
        if (m_valid[0] && m_ready[0]) take_result(0, m_p[0], m_count0, m_carryout[0]);
        if (m_valid[1] && m_ready[1]) take_result(1, m_p[1], {14'd0, m_count1}, m_carryout[1]);
    end

    initial begin
        int n;
        for (int g = 0; g < 2; g++) begin
            s_valid[g] = 1'b0; s_a[g] = '0; s_b[g] = '0; s_last[g] = 1'b0;
            m_ready[g] = 1'b1; exp_sum[g] = 0; exp_cnt[g] = 0;
        end
        grst_n = 1'b1;
        #1 grst_n = 1'b0;
        repeat (3) @(posedge gclk);
        #1;
        chk("rst_dsp_rst",    {63'd0, dsp_rst[0]},    64'd1);
        chk("rst_s_ready",    {63'd0, s_ready[0]},    64'd0);
        chk("rst_m_valid",    {63'd0, m_valid[0]},    64'd0);
        chk("rst_m_p",        64'(m_p[0]),            64'd0);
        chk("rst_m_count",    64'(m_count0),          64'd0);
        chk("rst_m_carryout", {63'd0, m_carryout[0]}, 64'd0);
        chk("rst_dsp_ce",     {63'd0, dsp_ce[0]},     64'd0);
        chk("rst_dsp_cep",    {63'd0, dsp_cep[0]},    64'd0);
        chk("rst_dsp_opmode", 64'(dsp_opmode[0]),     64'd0);
        chk("rst_dsp_a",      64'(dsp_a[0]),          64'd0);

        // release: one INIT cycle with dsp_rst high, then ACCEPT
        grst_n = 1'b1;
        chk("init_dsp_rst_hi", {63'd0, dsp_rst[0]}, 64'd1);
        chk("init_s_ready_lo", {63'd0, s_ready[0]}, 64'd0);
        @(posedge gclk); #1;
        chk("init_dsp_rst_lo", {63'd0, dsp_rst[0]}, 64'd0);
        chk("accept_s_ready",  {63'd0, s_ready[0]}, 64'd1);
        chk("accept_dsp_ce",   {63'd0, dsp_ce[0]},  64'd1);

        // single pair: opmode one cycle after, CEP two cycles after acceptance
        send(0, 18'd20, 18'd10, 1'b1);
        s_valid[0] = 1'b0;
        chk("op_first",   64'(dsp_opmode[0]),  64'h01);
        chk("cep_early",  {63'd0, dsp_cep[0]}, 64'd0);
        @(posedge gclk); #1;
        chk("cep_on",     {63'd0, dsp_cep[0]}, 64'd1);
        chk("op_default", 64'(dsp_opmode[0]),  64'h09);
        wait_q(0);

        // four pairs back-to-back, then with two-cycle gaps
        send(0, 18'd1, 18'd2, 1'b0);
        send(0, 18'd3, 18'd4, 1'b0);
        send(0, 18'd5, 18'd6, 1'b0);
        send(0, 18'd7, 18'd8, 1'b1);
        idle(0, 1);
        wait_q(0);
        send(0, 18'd1, 18'd2, 1'b0); idle(0, 2);
        send(0, 18'd3, 18'd4, 1'b0); idle(0, 2);
        send(0, 18'd5, 18'd6, 1'b0); idle(0, 2);
        send(0, 18'd7, 18'd8, 1'b1); idle(0, 1);
        wait_q(0);

        // consumer stalls for 5 cycles: result holds, input stays blocked
        m_ready[0] = 1'b0;
        send(0, 18'd1, 18'd2, 1'b0);
        send(0, 18'd3, 18'd4, 1'b0);
        send(0, 18'd5, 18'd6, 1'b0);
        send(0, 18'd7, 18'd8, 1'b1);
        s_valid[0] = 1'b0;
        n = 0;
        while (!m_valid[0] && n < 20) begin @(posedge gclk); #1; n++; end
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold_m_valid_%0d", k), {63'd0, m_valid[0]}, 64'd1);
            chk($sformatf("hold_m_p_%0d", k),     64'(m_p[0]),         64'h64);
            chk($sformatf("hold_s_ready_%0d", k), {63'd0, s_ready[0]}, 64'd0);
            @(posedge gclk); #1;
        end
        m_ready[0] = 1'b1;
        wait_q(0);
        send(0, 18'd2, 18'd3, 1'b1);
        idle(0, 1);
        wait_q(0);

        // reset in the middle of a packet: partial sum dropped, no result
        send(0, 18'd4, 18'd4, 1'b0);
        send(0, 18'd5, 18'd5, 1'b0);
        s_valid[0] = 1'b0;
        grst_n     = 1'b0;
        exp_sum[0] = 0;
        exp_cnt[0] = 0;
        #1;
        chk("mid_rst_m_p",     64'(m_p[0]),         64'd0);
        chk("mid_rst_m_count", 64'(m_count0),       64'd0);
        chk("mid_rst_m_valid", {63'd0, m_valid[0]}, 64'd0);
        chk("mid_rst_dsp_rst", {63'd0, dsp_rst[0]}, 64'd1);
        chk("mid_rst_dsp_cep", {63'd0, dsp_cep[0]}, 64'd0);
        repeat (2) @(posedge gclk);
        #1 grst_n = 1'b1;
        idle(0, 6);
        chk("mid_rst_no_result", {63'd0, m_valid[0]}, 64'd0);
        send(0, 18'd9, 18'd9, 1'b1);
        idle(0, 1);
        wait_q(0);

        // 2-bit counter: the third pair forces a packet end
        send(1, 18'd1, 18'd1, 1'b0);
        send(1, 18'd1, 18'd1, 1'b0);
        send(1, 18'd1, 18'd1, 1'b0);
        send(1, 18'd1, 18'd1, 1'b0);
        send(1, 18'd1, 18'd1, 1'b0);
        send(1, 18'd2, 18'd2, 1'b1);
        idle(1, 1);
        wait_q(1);
        wait_q(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Controller that drives one DSP slice instance as a streaming multiply-accumulate engine.
- Accepts a packet of (a, b) operand pairs over a valid/ready stream and sequences the slice's opmode, clock enables and reset so that P = sum of a*b over the packet.
- Returns the accumulated result and sample count on a valid/ready result port.
- Sits between the operand source and the slice instance; the slice is configured with A1REG=B1REG=MREG=PREG=OPMODEREG=1, A0REG=B0REG=0, RSTTYPE="SYNC", B_INPUT="DIRECT".

Parameters:
- P_LAT, 3: clock edges from dsp_a/dsp_b presented to the result appearing on dsp_p.
- OP_DELAY, 1: cycles between presenting a sample and presenting its opmode; compensates for the registered opmode path.
- CNT_W, 16: width of the sample counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  operand pair valid.
- s_ready  out  1  operand pair accepted when s_valid and s_ready are both high.
- s_a  in  18  multiplicand.
- s_b  in  18  multiplier.
- s_last  in  1  marks the final pair of a packet; ignored unless s_valid is high.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_p  out  48  accumulated result.
- m_carryout  out  1  slice CARRYOUT at result time.
- m_count  out  CNT_W  number of pairs accumulated.
- dsp_a  out  18  to slice A.
- dsp_b  out  18  to slice B.
- dsp_opmode  out  8  to slice opmode.
- dsp_ce  out  1  to CEA, CEB, CEM and CEOPMODE.
- dsp_cep  out  1  to CEP.
- dsp_rst  out  1  to all slice RSTx inputs; synchronous, active-high.
- dsp_p  in  48  from slice P.
- dsp_carryout  in  1  from slice CARRYOUT.

Behaviour:
- Async reset (rst_n low) forces:
  - state INIT; s_ready=0, m_valid=0, m_count=0, m_p=0, m_carryout=0;
  - dsp_rst=1, dsp_ce=0, dsp_cep=0, dsp_opmode=0, dsp_a=0, dsp_b=0;
  - internal pipelines cleared.
- States:
  - INIT: dsp_rst=1 for exactly one cycle after rst_n deasserts, then go to ACCEPT.
  - ACCEPT: s_ready=1 and dsp_ce=1. Each accepted pair drives dsp_a/dsp_b in the same cycle (combinational pass-through from s_a/s_b). The counter increments per accepted pair. Accepting a pair with s_last=1, or the pair that makes the count reach 2^CNT_W-1, goes to DRAIN.
  - DRAIN: s_ready=0. Lasts P_LAT cycles while the pipeline empties, then go to RESULT.
  - RESULT: m_valid=1; m_p=dsp_p; m_carryout=dsp_carryout; m_count=counter. All of these hold stable until m_ready. On the handshake, clear the counter and return to ACCEPT the next cycle.
- Sample tracking pipeline: (valid, first) shift register, P_LAT deep.
  - "first" = first accepted pair since the last result.
- Opmode, presented OP_DELAY cycles after its pair:
  - 8'b0000_0001 (X=M, Z=0) for the first pair;
  - 8'b0000_1001 (X=M, Z=P) for any other pair;
  - otherwise held at 8'b0000_1001.
- dsp_cep: high in exactly the cycle before the P register edge that consumes a valid sample, i.e. P_LAT-1 cycles after acceptance. It is low for bubbles, so P holds across gaps in s_valid.
- Result latency: last accept edge to m_valid high is P_LAT+1 cycles.
- Pre-adder, post-subtract and carry-in are never used: opmode bits 7:4 are always 0.
- Boundary conditions:
  - s_valid low mid-packet: no count change, no P change.
  - Single-pair packet is legal.
  - Counter saturation forces a packet end exactly as s_last does.
  - rst_n asserted mid-packet or mid-result: the partial sum is discarded and no m_valid is issued; the next packet is unaffected because the first opmode zeroes Z.
  - m_ready held high before m_valid: the handshake completes in the first RESULT cycle.

Decomposition:
- Shared package dsp_ctrl_pkg holds:
  - opmode constants OPM_MUL_ONLY=8'h01, OPM_MUL_ACC=8'h09;
  - the state enum (INIT, ACCEPT, DRAIN, RESULT);
  - the default slice parameter set listed above.
- One natural sub-module: dsp_tag_pipe, the parameterised (valid, first) delay line with taps at OP_DELAY and P_LAT-1.
- The top level instantiates dsp_mac_sequencer and the slice side by side.

Test Plan:
- Reset, then release: dsp_rst is high for exactly one cycle after rst_n rises; all m_* outputs are 0; s_ready rises the following cycle.
- Single pair a=20, b=10, s_last=1: m_valid after P_LAT+1 cycles with m_p=0xC8, m_count=1, m_carryout=0.
- Pairs (1,2),(3,4),(5,6),(7,8) sent back-to-back, then the same packet with s_valid low for 2 cycles between each pair: both give m_p=0x64, m_count=4.
- m_ready held low 5 cycles during RESULT: m_valid stays 1, m_p stays 0x64, s_ready stays 0; the next packet (2,3) gives m_p=0x6, with no leftover sum from the previous packet.
- rst_n pulsed low after 2 pairs of a 4-pair packet: outputs return to reset values, no m_valid; a new packet (9,9) gives m_p=0x51, m_count=1.
- CNT_W=2, send 5 pairs of (1,1) with no s_last: a result with m_count=3, m_p=0x3 is forced; the remaining 2 pairs start a new packet.
